// File: rtl/pixel_scan_sequencer_pkg.sv
// Shared types and constants for the pixel scan sequencer: fixed-point screen coordinates
// and scan FSM state encodings.
package pixel_scan_sequencer_pkg;

    typedef logic [31:0] fp_t;

    localparam int unsigned FP_FRAC_BITS = 21;

    typedef logic [2:0] scan_state_e;

    localparam scan_state_e StIdle  = 3'd0;
    localparam scan_state_e StIssue = 3'd1;
    localparam scan_state_e StDrain = 3'd2;
    localparam scan_state_e StDone  = 3'd3;
    localparam scan_state_e StAbort = 3'd4;

    // Integer pixel coordinate to Q11.21; sign bit stays 0 for coordinates below 1024.
    function automatic fp_t coord_to_fp(input logic [15:0] coord);
        return {16'h0000, coord} << FP_FRAC_BITS;
    endfunction

endpackage

// File: rtl/pixel_scan_sequencer_if.sv
// Job bus between the scan sequencer (master) and the ray-marcher (slave): coordinate
// pair with issue strobe out, completion strobe back.
interface pixel_scan_sequencer_if;
    import pixel_scan_sequencer_pkg::*;

    fp_t  screen_x;
    fp_t  screen_y;
    logic valid_in;
    logic pix_done;

    modport master (
        output screen_x,
        output screen_y,
        output valid_in,
        input  pix_done
    );

    modport slave (
        input  screen_x,
        input  screen_y,
        input  valid_in,
        output pix_done
    );

endinterface

// File: rtl/pixel_scan_sequencer_credit_counter.sv
// Outstanding-job counter: +1 per issue, -1 per completion, saturating at both ends,
// with a sticky flag for completions that arrive with nothing outstanding.
module pixel_scan_sequencer_credit_counter #(
    parameter int unsigned MAX_INFLIGHT = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                inc_i,
    input  logic                                dec_i,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   count_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic                                underflow_o
);

    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;
    logic          inc_ok, dec_ok;

    assign full_o  = (count_q == CW'(MAX_INFLIGHT));
    assign empty_o = (count_q == '0);
    assign inc_ok  = inc_i && !full_o;
    assign dec_ok  = dec_i && !empty_o;

    // Simultaneous accepted inc and dec cancel out.
    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q | (dec_i && empty_o);
        if (inc_ok && !dec_ok) begin
            count_d = count_q + CW'(1);
        end else if (!inc_ok && dec_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Raster-scan job source for the ray-marcher: issues one Q11.21 (x, y) pair per pixel,
// throttled by completion credits and a minimum issue gap.
module pixel_scan_sequencer
    import pixel_scan_sequencer_pkg::*;
#(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned MAX_INFLIGHT = 1,
    parameter int unsigned ISSUE_GAP    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              continuous_i,
    input  logic                              abort_i,
    pixel_scan_sequencer_if.master            job_if,
    output logic                              busy_o,
    output logic                              frame_done_o,
    output logic [15:0]                       frame_count_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
    output logic                              err_underflow_o
);

    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    scan_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic issue;
    logic credit_full, credit_empty;
    logic x_last, y_last;

    pixel_scan_sequencer_credit_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (issue),
        .dec_i       (job_if.pix_done),
        .count_o     (inflight_o),
        .full_o      (credit_full),
        .empty_o     (credit_empty),
        .underflow_o (err_underflow_o)
    );

    assign x_last = (x_q == XW'(H_RES - 1));
    assign y_last = (y_q == YW'(V_RES - 1));

    // Issue decision is combinational so abort suppresses a strobe in the same cycle.
    assign issue = (state_q == StIssue) && !credit_full && (gap_q == '0) && !abort_i;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StIssue;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StIssue: begin
                if (abort_i) begin
                    state_d = StAbort;
                end else if (issue) begin
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) begin
                            y_d     = '0;
                            state_d = StDrain;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            StDrain: begin
                if (abort_i) begin
                    state_d = StAbort;
                end else if (credit_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = continuous_i ? StIssue : StIdle;
            end
            StAbort: begin
                if (credit_empty) begin
                    state_d = StIdle;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
    end

    always_comb begin
        gap_d = gap_q;
        if (issue) begin
            gap_d = GW'(ISSUE_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    assign frame_count_d = (state_q == StDone) ? frame_count_q + 16'd1 : frame_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            gap_q         <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            gap_q         <= gap_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign job_if.valid_in = issue;
    assign job_if.screen_x = coord_to_fp(16'(x_q));
    assign job_if.screen_y = coord_to_fp(16'(y_q));

    assign busy_o        = (state_q != StIdle);
    assign frame_done_o  = (state_q == StDone);
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Bench for pixel_scan_sequencer: two 4x2 instances (strict issue/wait, and 3-deep
// back-to-back) driven per cycle, with expected coordinates queued at start.
module tb_pixel_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;

    // Instance A: H=4, V=2, MAX_INFLIGHT=1, ISSUE_GAP=1
    logic        a_rst, a_start, a_cont, a_abort;
    logic        a_busy, a_frame_done, a_err;
    logic [15:0] a_frame_count;
    logic [0:0]  a_inflight;
    pixel_scan_sequencer_if a_if ();

    pixel_scan_sequencer #(
        .H_RES (4), .V_RES (2), .MAX_INFLIGHT (1), .ISSUE_GAP (1)
    ) dut_a (
        .clk             (clk),
        .rst             (a_rst),
        .start_i         (a_start),
        .continuous_i    (a_cont),
        .abort_i         (a_abort),
        .job_if          (a_if),
        .busy_o          (a_busy),
        .frame_done_o    (a_frame_done),
        .frame_count_o   (a_frame_count),
        .inflight_o      (a_inflight),
        .err_underflow_o (a_err)
    );

    // Instance B: H=4, V=2, MAX_INFLIGHT=3, ISSUE_GAP=0
    logic        b_rst, b_start, b_cont, b_abort;
    logic        b_busy, b_frame_done, b_err;
    logic [15:0] b_frame_count;
    logic [1:0]  b_inflight;
    pixel_scan_sequencer_if b_if ();

    pixel_scan_sequencer #(
        .H_RES (4), .V_RES (2), .MAX_INFLIGHT (3), .ISSUE_GAP (0)
    ) dut_b (
        .clk             (clk),
        .rst             (b_rst),
        .start_i         (b_start),
        .continuous_i    (b_cont),
        .abort_i         (b_abort),
        .job_if          (b_if),
        .busy_o          (b_busy),
        .frame_done_o    (b_frame_done),
        .frame_count_o   (b_frame_count),
        .inflight_o      (b_inflight),
        .err_underflow_o (b_err)
    );

    logic [63:0] a_exp[$];
    logic [63:0] b_exp[$];
    int          a_due[$];
    int          b_due[$];
    bit          a_resp = 0, b_resp = 0;
    int          a_delay = 3, b_delay = 2;
    int          a_issued = 0, b_issued = 0;
    int          a_fd = 0, b_fd = 0;

    task automatic push_frame_a();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                a_exp.push_back({32'(x) << 21, 32'(y) << 21});
    endtask

    task automatic push_frame_b();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                b_exp.push_back({32'(x) << 21, 32'(y) << 21});
    endtask

    // One cycle on A: drive inputs after the edge, auto-complete due jobs, sample at negedge.
    task automatic step_a(input logic st, input logic ab, input logic pix);
        logic [63:0] e;
        @(posedge clk);
        #1;
        a_start = st;
        a_abort = ab;
        a_if.pix_done = pix;
        if (a_resp && a_due.size() > 0 && a_due[0] <= cyc) begin
            void'(a_due.pop_front());
            a_if.pix_done = 1'b1;
        end
        @(negedge clk);
        if (a_if.valid_in === 1'b1) begin
            a_issued++;
            if (a_resp) a_due.push_back(cyc + a_delay);
            tests++;
            if (a_exp.size() == 0) begin
                failed++;
                $display("FAIL a_issue: unexpected issue x=%h y=%h", a_if.screen_x, a_if.screen_y);
            end else begin
                e = a_exp.pop_front();
                if ({a_if.screen_x, a_if.screen_y} !== e) begin
                    failed++;
                    $display("FAIL a_coord: got x=%h y=%h, want x=%h y=%h",
                             a_if.screen_x, a_if.screen_y, e[63:32], e[31:0]);
                end
            end
        end
        if (a_frame_done === 1'b1) a_fd++;
    endtask

    task automatic step_b(input logic st, input logic ab, input logic pix);
        logic [63:0] e;
        @(posedge clk);
        #1;
        b_start = st;
        b_abort = ab;
        b_if.pix_done = pix;
        if (b_resp && b_due.size() > 0 && b_due[0] <= cyc) begin
            void'(b_due.pop_front());
            b_if.pix_done = 1'b1;
        end
        @(negedge clk);
        if (b_if.valid_in === 1'b1) begin
            b_issued++;
            if (b_resp) b_due.push_back(cyc + b_delay);
            tests++;
            if (b_exp.size() == 0) begin
                failed++;
                $display("FAIL b_issue: unexpected issue x=%h y=%h", b_if.screen_x, b_if.screen_y);
            end else begin
                e = b_exp.pop_front();
                if ({b_if.screen_x, b_if.screen_y} !== e) begin
                    failed++;
                    $display("FAIL b_coord: got x=%h y=%h, want x=%h y=%h",
                             b_if.screen_x, b_if.screen_y, e[63:32], e[31:0]);
                end
            end
        end
        if (b_frame_done === 1'b1) b_fd++;
    endtask

    task automatic test_reset();
        a_rst = 1'b1;
        b_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_busy, a_if.valid_in, a_frame_done, a_err, a_inflight} !== 5'b0) begin
            failed++;
            $display("FAIL reset_a_flags: busy/valid/fd/err/infl=%b want 00000",
                     {a_busy, a_if.valid_in, a_frame_done, a_err, a_inflight});
        end
        tests++;
        if ({a_if.screen_x, a_if.screen_y, a_frame_count} !== 80'h0) begin
            failed++;
            $display("FAIL reset_a_data: x=%h y=%h count=%h want 0",
                     a_if.screen_x, a_if.screen_y, a_frame_count);
        end
        tests++;
        if ({b_busy, b_if.valid_in, b_frame_done, b_err, b_inflight, b_frame_count} !== 21'b0) begin
            failed++;
            $display("FAIL reset_b: busy=%b valid=%b fd=%b err=%b infl=%0d count=%0d want all 0",
                     b_busy, b_if.valid_in, b_frame_done, b_err, b_inflight, b_frame_count);
        end
    endtask

    task automatic test_raster();
        a_exp.delete();
        a_due.delete();
        push_frame_a();
        a_resp = 1;
        a_delay = 3;
        a_issued = 0;
        a_fd = 0;
        step_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && a_fd == 0; i++) step_a(1'b0, 1'b0, 1'b0);
        repeat (5) step_a(1'b0, 1'b0, 1'b0);
        tests++;
        if (a_issued != 8 || a_exp.size() != 0) begin
            failed++;
            $display("FAIL raster_issues: issued=%0d left=%0d want 8/0", a_issued, a_exp.size());
        end
        tests++;
        if (a_fd != 1) begin
            failed++;
            $display("FAIL raster_frame_done: pulses=%0d want 1", a_fd);
        end
        tests++;
        if (a_frame_count !== 16'd1 || a_busy !== 1'b0) begin
            failed++;
            $display("FAIL raster_end: count=%0d busy=%b want 1/0", a_frame_count, a_busy);
        end
    endtask

    task automatic test_credit_stall();
        int first, last;
        b_exp.delete();
        push_frame_b();
        b_resp = 0;
        b_issued = 0;
        first = -1;
        last = -1;
        step_b(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_b(1'b0, 1'b0, 1'b0);
            if (b_if.valid_in === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        tests++;
        if (b_issued != 3 || last - first != 2) begin
            failed++;
            $display("FAIL stall_burst: issued=%0d span=%0d want 3/2", b_issued, last - first);
        end
        tests++;
        if (b_inflight !== 2'd3) begin
            failed++;
            $display("FAIL stall_inflight: got %0d want 3", b_inflight);
        end
        step_b(1'b0, 1'b0, 1'b1);
        repeat (5) step_b(1'b0, 1'b0, 1'b0);
        tests++;
        if (b_issued != 4 || b_inflight !== 2'd3) begin
            failed++;
            $display("FAIL stall_refill: issued=%0d infl=%0d want 4/3", b_issued, b_inflight);
        end
    endtask

    task automatic test_abort();
        bit busy_ok;
        step_b(1'b0, 1'b0, 1'b1);
        repeat (2) step_b(1'b0, 1'b0, 1'b0);
        tests++;
        if (b_issued != 5 || b_inflight !== 2'd3) begin
            failed++;
            $display("FAIL abort_pre: issued=%0d infl=%0d want 5/3", b_issued, b_inflight);
        end
        // Abort with a completion in the same cycle leaves 2 jobs outstanding.
        step_b(1'b0, 1'b1, 1'b1);
        b_exp.delete();
        busy_ok = 1;
        repeat (4) begin
            step_b(1'b0, 1'b0, 1'b0);
            if (b_busy !== 1'b1 || b_inflight !== 2'd2) busy_ok = 0;
        end
        step_b(1'b0, 1'b0, 1'b1);
        step_b(1'b0, 1'b0, 1'b0);
        if (b_busy !== 1'b1 || b_inflight !== 2'd1) busy_ok = 0;
        tests++;
        if (!busy_ok) begin
            failed++;
            $display("FAIL abort_drain: busy=%b infl=%0d want busy held while draining",
                     b_busy, b_inflight);
        end
        step_b(1'b0, 1'b0, 1'b1);
        step_b(1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 1'b0);
        tests++;
        if (b_busy !== 1'b0 || b_issued != 5) begin
            failed++;
            $display("FAIL abort_idle: busy=%b issued=%0d want 0/5", b_busy, b_issued);
        end
        tests++;
        if (b_fd != 0 || b_frame_count !== 16'd0) begin
            failed++;
            $display("FAIL abort_no_frame: fd=%0d count=%0d want 0/0", b_fd, b_frame_count);
        end
    endtask

    task automatic test_back_to_back();
        push_frame_b();
        step_b(1'b1, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 1'b0);
        tests++;
        if (b_if.valid_in !== 1'b1) begin
            failed++;
            $display("FAIL restart_issue: valid_in=%b want 1", b_if.valid_in);
        end
        step_b(1'b0, 1'b0, 1'b1);
        tests++;
        if (b_if.valid_in !== 1'b1 || b_inflight !== 2'd1) begin
            failed++;
            $display("FAIL same_cycle_pre: valid=%b infl=%0d want 1/1", b_if.valid_in, b_inflight);
        end
        b_resp = 1;
        b_delay = 2;
        step_b(1'b0, 1'b0, 1'b0);
        tests++;
        if (b_if.valid_in !== 1'b1 || b_inflight !== 2'd1) begin
            failed++;
            $display("FAIL same_cycle_post: valid=%b infl=%0d want 1/1", b_if.valid_in, b_inflight);
        end
        b_due.push_front(cyc + 1);
        for (int i = 0; i < 200 && b_fd == 0; i++) step_b(1'b0, 1'b0, 1'b0);
        repeat (4) step_b(1'b0, 1'b0, 1'b0);
        tests++;
        if (b_fd != 1 || b_frame_count !== 16'd1 || b_exp.size() != 0) begin
            failed++;
            $display("FAIL b_frame: fd=%0d count=%0d left=%0d want 1/1/0",
                     b_fd, b_frame_count, b_exp.size());
        end
        tests++;
        if (b_inflight !== 2'd0 || b_err !== 1'b0 || b_busy !== 1'b0) begin
            failed++;
            $display("FAIL b_end: infl=%0d err=%b busy=%b want 0/0/0", b_inflight, b_err, b_busy);
        end
    endtask

    task automatic test_continuous();
        bit pending;
        int fd_before;
        @(posedge clk);
        #1;
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        a_exp.delete();
        a_due.delete();
        repeat (3) push_frame_a();
        a_resp = 1;
        a_delay = 3;
        a_fd = 0;
        a_cont = 1'b1;
        pending = 0;
        step_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600 && a_fd < 3; i++) begin
            fd_before = a_fd;
            step_a(1'b0, 1'b0, 1'b0);
            if (pending) begin
                pending = 0;
                tests++;
                if (a_if.valid_in !== 1'b1) begin
                    failed++;
                    $display("FAIL cont_restart: valid_in=%b after frame %0d want 1",
                             a_if.valid_in, a_fd);
                end
                if (a_fd == 2) a_cont = 1'b0;
            end
            if (a_fd != fd_before && a_fd < 3) pending = 1;
        end
        repeat (3) step_a(1'b0, 1'b0, 1'b0);
        tests++;
        if (a_fd != 3 || a_frame_count !== 16'd3 || a_busy !== 1'b0 || a_exp.size() != 0) begin
            failed++;
            $display("FAIL cont_frames: fd=%0d count=%0d busy=%b left=%0d want 3/3/0/0",
                     a_fd, a_frame_count, a_busy, a_exp.size());
        end
        tests++;
        if (a_err !== 1'b0) begin
            failed++;
            $display("FAIL underflow_pre: err=%b want 0", a_err);
        end
        step_a(1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b0, 1'b0);
        repeat (3) step_a(1'b0, 1'b0, 1'b0);
        tests++;
        if (a_err !== 1'b1 || a_inflight !== 1'b0) begin
            failed++;
            $display("FAIL underflow_sticky: err=%b infl=%0d want 1/0", a_err, a_inflight);
        end
    endtask

    task automatic test_mid_reset();
        a_exp.delete();
        a_due.delete();
        push_frame_a();
        a_issued = 0;
        step_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100 && a_issued < 3; i++) step_a(1'b0, 1'b0, 1'b0);
        tests++;
        if (a_busy !== 1'b1 || a_issued != 3) begin
            failed++;
            $display("FAIL midrst_pre: busy=%b issued=%0d want 1/3", a_busy, a_issued);
        end
        @(posedge clk);
        #1;
        a_rst = 1'b1;
        a_if.pix_done = 1'b0;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_busy, a_if.valid_in, a_frame_done, a_err, a_inflight} !== 5'b0 ||
            {a_if.screen_x, a_if.screen_y, a_frame_count} !== 80'h0) begin
            failed++;
            $display("FAIL midrst_state: busy=%b valid=%b err=%b infl=%0d x=%h y=%h count=%0d",
                     a_busy, a_if.valid_in, a_err, a_inflight, a_if.screen_x, a_if.screen_y,
                     a_frame_count);
        end
        a_exp.delete();
        a_due.delete();
        push_frame_a();
        a_issued = 0;
        a_fd = 0;
        step_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && a_fd == 0; i++) step_a(1'b0, 1'b0, 1'b0);
        repeat (3) step_a(1'b0, 1'b0, 1'b0);
        tests++;
        if (a_issued != 8 || a_fd != 1 || a_frame_count !== 16'd1) begin
            failed++;
            $display("FAIL midrst_restart: issued=%0d fd=%0d count=%0d want 8/1/1",
                     a_issued, a_fd, a_frame_count);
        end
    endtask

    initial begin
        a_rst = 1'b1;
        a_start = 1'b0;
        a_cont = 1'b0;
        a_abort = 1'b0;
        a_if.pix_done = 1'b0;
        b_rst = 1'b1;
        b_start = 1'b0;
        b_cont = 1'b0;
        b_abort = 1'b0;
        b_if.pix_done = 1'b0;

        test_reset();
        test_raster();
        test_credit_stall();
        test_abort();
        test_back_to_back();
        test_continuous();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
